// File: rtl/n_serializer_tx.sv
// Parallel-in, serial-out transmitter: one N-bit word per in handshake, one bit per ser beat.
// Optional trailing even-parity bit; all outputs are registered, in_ready depends on state only.
module n_serializer_tx #(
   parameter int N         = 8,
   parameter int MSB_FIRST = 1,
   parameter int PARITY_EN = 0
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         in_valid,
   input  logic [N-1:0] in_data,
   output logic         in_ready,
   output logic         ser_valid,
   output logic         ser_data,
   output logic         ser_first,
   output logic         ser_last,
   input  logic         ser_ready,
   output logic         busy
);

   localparam int CW = (N > 2) ? $clog2(N) : 1;

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PAR} state_t;

   state_t         state_q;
   logic [N-1:0]   sreg_q;
   logic [N-1:0]   sreg_d;
   logic [CW-1:0]  cnt_q;
   logic           par_q;
   logic           in_ready_q;
   logic           ser_valid_q;
   logic           ser_data_q;
   logic           ser_first_q;
   logic           ser_last_q;

   function automatic logic head(input logic [N-1:0] v);
      return (MSB_FIRST != 0) ? v[N-1] : v[0];
   endfunction

   always_comb begin
      sreg_d = (MSB_FIRST != 0) ? {sreg_q[N-2:0], 1'b0} : {1'b0, sreg_q[N-1:1]};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         sreg_q      <= '0;
         cnt_q       <= '0;
         par_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         ser_valid_q <= 1'b0;
         ser_data_q  <= 1'b0;
         ser_first_q <= 1'b0;
         ser_last_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  state_q     <= S_DATA;
                  sreg_q      <= in_data;
                  cnt_q       <= '0;
                  par_q       <= ^in_data;
                  in_ready_q  <= 1'b0;
                  ser_valid_q <= 1'b1;
                  ser_data_q  <= head(in_data);
                  ser_first_q <= 1'b1;
                  ser_last_q  <= 1'b0;
               end
            end
            S_DATA: begin
               if (ser_ready) begin
                  sreg_q      <= sreg_d;
                  ser_first_q <= 1'b0;
                  // The counter holds on the final beat so it never wraps mid-frame.
                  if (cnt_q == CW'(N-1)) begin
                     if (PARITY_EN != 0) begin
                        state_q    <= S_PAR;
                        ser_data_q <= par_q;
                        ser_last_q <= 1'b1;
                     end else begin
                        state_q     <= S_IDLE;
                        in_ready_q  <= 1'b1;
                        ser_valid_q <= 1'b0;
                        ser_data_q  <= 1'b0;
                        ser_last_q  <= 1'b0;
                     end
                  end else begin
                     cnt_q      <= cnt_q + 1'b1;
                     ser_data_q <= head(sreg_d);
                     ser_last_q <= (cnt_q == CW'(N-2)) && (PARITY_EN == 0);
                  end
               end
            end
            S_PAR: begin
               if (ser_ready) begin
                  state_q     <= S_IDLE;
                  in_ready_q  <= 1'b1;
                  ser_valid_q <= 1'b0;
                  ser_data_q  <= 1'b0;
                  ser_last_q  <= 1'b0;
               end
            end
            default: begin
               state_q     <= S_IDLE;
               in_ready_q  <= 1'b1;
               ser_valid_q <= 1'b0;
               ser_data_q  <= 1'b0;
               ser_first_q <= 1'b0;
               ser_last_q  <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign busy      = ~in_ready_q;
   assign ser_valid = ser_valid_q;
   assign ser_data  = ser_data_q;
   assign ser_first = ser_first_q;
   assign ser_last  = ser_last_q;

endmodule

// File: tb/tb_n_serializer_tx.sv
// Scoreboard bench for n_serializer_tx: three instances (MSB-first, LSB-first, MSB-first+parity).
// Stimulus pushes hand-computed bit sequences; a negedge monitor pops and compares every beat.
module tb_n_serializer_tx;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] in_valid = '0;
   logic [7:0] in_data [3];
   logic [2:0] in_ready, ser_valid, ser_data, ser_first, ser_last, busy;
   logic [2:0] ser_ready = 3'b111;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;

   typedef struct packed {logic d; logic f; logic l;} exp_t;
   exp_t q0[$], q1[$], q2[$];

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   n_serializer_tx #(.N(8), .MSB_FIRST(1), .PARITY_EN(0)) u0 (
      .clock(clock), .reset(reset), .in_valid(in_valid[0]), .in_data(in_data[0]),
      .in_ready(in_ready[0]), .ser_valid(ser_valid[0]), .ser_data(ser_data[0]),
      .ser_first(ser_first[0]), .ser_last(ser_last[0]), .ser_ready(ser_ready[0]), .busy(busy[0]));
   n_serializer_tx #(.N(8), .MSB_FIRST(0), .PARITY_EN(0)) u1 (
      .clock(clock), .reset(reset), .in_valid(in_valid[1]), .in_data(in_data[1]),
      .in_ready(in_ready[1]), .ser_valid(ser_valid[1]), .ser_data(ser_data[1]),
      .ser_first(ser_first[1]), .ser_last(ser_last[1]), .ser_ready(ser_ready[1]), .busy(busy[1]));
   n_serializer_tx #(.N(8), .MSB_FIRST(1), .PARITY_EN(1)) u2 (
      .clock(clock), .reset(reset), .in_valid(in_valid[2]), .in_data(in_data[2]),
      .in_ready(in_ready[2]), .ser_valid(ser_valid[2]), .ser_data(ser_data[2]),
      .ser_first(ser_first[2]), .ser_last(ser_last[2]), .ser_ready(ser_ready[2]), .busy(busy[2]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // seq holds the bits in transmit order, first bit at position nb-1.
   task automatic push_frame(input int k, input logic [8:0] seq, input int nb, input bit with_last);
      exp_t e;
      for (int i = 0; i < nb; i++) begin
         e.d = seq[nb-1-i];
         e.f = (i == 0);
         e.l = with_last && (i == nb-1);
         case (k)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
         endcase
      end
   endtask

   task automatic check_beat(input int k);
      exp_t e;
      bit   have;
      have = 0;
      e    = '0;
      case (k)
         0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1; end
         1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1; end
         default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1; end
      endcase
      nvec++;
      if (!have) begin
         nerr++;
         $display("FAIL beat u%0d unexpected: got d/f/l=%b%b%b, required no beat",
                  k, ser_data[k], ser_first[k], ser_last[k]);
      end else if ({ser_data[k], ser_first[k], ser_last[k]} !== 3'(e)) begin
         nerr++;
         $display("FAIL beat u%0d: got d/f/l=%b%b%b, required %b%b%b",
                  k, ser_data[k], ser_first[k], ser_last[k], e.d, e.f, e.l);
      end
   endtask

   always @(negedge clock) begin
      if (!reset) begin
         for (int k = 0; k < 3; k++)
            if (ser_valid[k] && ser_ready[k]) check_beat(k);
      end
   end

   task automatic send(input int k, input logic [7:0] d, input bit drop, output int acc_cyc);
      int t;
      bit got;
      t   = 0;
      got = 0;
      in_valid[k] = 1'b1;
      in_data[k]  = d;
      while (!got && t < 50) begin
         @(negedge clock);
         got = in_ready[k];
         @(posedge clock);
         #1;
         t++;
      end
      acc_cyc = cyc;
      if (!got) chk($sformatf("accept_timeout_u%0d", k), 32'(got), 32'd1);
      if (drop) in_valid[k] = 1'b0;
   endtask

   task automatic wait_idle(input int k);
      int t;
      bit idle;
      t    = 0;
      idle = 0;
      while (!idle && t < 100) begin
         @(negedge clock);
         idle = in_ready[k];
         t++;
      end
      if (!idle) chk($sformatf("idle_timeout_u%0d", k), 32'(idle), 32'd1);
      @(posedge clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, required finish");
      $fatal(1);
   end

   initial begin
      int t1, t2;
      for (int k = 0; k < 3; k++) in_data[k] = 8'h00;
      repeat (2) @(posedge clock);
      @(negedge clock);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst_in_ready_u%0d", k), 32'(in_ready[k]), 32'd1);
         chk($sformatf("rst_busy_u%0d", k), 32'(busy[k]), 32'd0);
         chk($sformatf("rst_outs_u%0d", k),
             {29'd0, ser_valid[k], ser_data[k], ser_first[k] | ser_last[k]}, 32'd0);
      end
      @(posedge clock);
      #1;
      reset = 1'b0;

      // 8'hA5 MSB-first, with in_ready timing around the frame
      send(0, 8'hA5, 1, t1);
      push_frame(0, 9'b0_1010_0101, 8, 1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         chk($sformatf("a5_in_ready_c%0d", i), 32'(in_ready[0]), 32'd0);
         chk($sformatf("a5_busy_c%0d", i), 32'(busy[0]), 32'd1);
      end
      @(negedge clock);
      chk("a5_in_ready_after", 32'(in_ready[0]), 32'd1);
      chk("a5_busy_after", 32'(busy[0]), 32'd0);
      @(posedge clock);
      #1;

      // 8'h1E LSB-first: 0,1,1,1,1,0,0,0
      send(1, 8'h1E, 1, t1);
      push_frame(1, 9'b0_0111_1000, 8, 1);
      wait_idle(1);

      // parity: 8'h07 -> parity 1, 8'h03 -> parity 0
      send(2, 8'h07, 1, t1);
      push_frame(2, 9'b0000_0111_1, 9, 1);
      wait_idle(2);
      send(2, 8'h03, 1, t1);
      push_frame(2, 9'b0000_0011_0, 9, 1);
      wait_idle(2);

      // backpressure: 8'hF0, stall 3 cycles after bit 3
      send(0, 8'hF0, 1, t1);
      push_frame(0, 9'b0_1111_0000, 8, 1);
      repeat (3) @(posedge clock);
      #1;
      ser_ready[0] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk($sformatf("stall_valid_c%0d", i), 32'(ser_valid[0]), 32'd1);
         chk($sformatf("stall_data_c%0d", i), 32'(ser_data[0]), 32'd1);
      end
      @(posedge clock);
      #1;
      ser_ready[0] = 1'b1;
      wait_idle(0);

      // reset mid-frame after 4 bits of 8'hAA
      send(0, 8'hAA, 1, t1);
      push_frame(0, 9'b0_0000_1010, 4, 0);
      repeat (4) @(posedge clock);
      #1;
      reset        = 1'b1;
      ser_ready[0] = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      chk("abort_ser_valid", 32'(ser_valid[0]), 32'd0);
      chk("abort_in_ready", 32'(in_ready[0]), 32'd1);
      chk("abort_busy", 32'(busy[0]), 32'd0);
      @(posedge clock);
      #1;
      ser_ready[0] = 1'b1;
      send(0, 8'hFF, 1, t1);
      push_frame(0, 9'b0_1111_1111, 8, 1);
      wait_idle(0);

      // back-to-back with in_valid held and in_data changing while busy
      send(0, 8'h81, 0, t1);
      push_frame(0, 9'b0_1000_0001, 8, 1);
      send(0, 8'h7E, 1, t2);
      push_frame(0, 9'b0_0111_1110, 8, 1);
      chk("b2b_accept_spacing", 32'(t2 - t1), 32'd9);
      wait_idle(0);

      repeat (3) @(posedge clock);
      chk("q0_drained", 32'(q0.size()), 32'd0);
      chk("q1_drained", 32'(q1.size()), 32'd0);
      chk("q2_drained", 32'(q2.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/n_serializer_tx.md
Name: n_serializer_tx

Overview:
- Parallel-in, serial-out transmitter for words produced by the team's N-bit load-enable registers.
- Accepts one N-bit word per valid/ready handshake, then shifts it out one bit per accepted serial beat.
- Optionally appends an even-parity bit.
- Sits between a datapath register stage and a 1-bit serial link or downstream deserializer.

Parameters:
- N, 8, data word width in bits (N >= 2).
- MSB_FIRST, 1, 1 = bit N-1 sent first; 0 = bit 0 sent first.
- PARITY_EN, 0, 1 = append one even-parity bit after the data bits.

Ports:
- clock  input  1  rising-edge clock, single domain.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream word available.
- in_data  input  N  word to transmit; sampled only on an accepted handshake.
- in_ready  output  1  block can accept a word.
- ser_valid  output  1  ser_data holds a valid bit.
- ser_data  output  1  current serial bit.
- ser_first  output  1  current bit is the first bit of the frame.
- ser_last  output  1  current bit is the last bit of the frame (parity bit if PARITY_EN=1).
- ser_ready  input  1  downstream accepts the current bit.
- busy  output  1  frame in progress (equal to ~in_ready).

Behaviour:
- Interface: one clock, named clock. Reset is synchronous and active-high, named reset. All state changes occur on the rising edge of clock.
- Reset values: state=IDLE, shift register=0, bit counter=0, parity register=0, in_ready=1, ser_valid=0, ser_data=0, ser_first=0, ser_last=0, busy=0.
- Reset wins over every other input in the same cycle.
- Reset mid-frame aborts the frame: remaining bits are discarded, and IDLE holds from the next cycle.
- FSM states: IDLE, DATA, PAR (PAR exists only when PARITY_EN=1).
- IDLE:
  - in_ready=1, ser_valid=0.
  - On in_valid&in_ready: load in_data into the shift register, counter=0, parity=^in_data, go to DATA.
- DATA:
  - ser_valid=1, in_ready=0.
  - ser_data = MSB_FIRST ? sreg[N-1] : sreg[0].
  - ser_first = (counter==0).
  - ser_last = (counter==N-1) && !PARITY_EN.
- Beat transfer: occurs on ser_valid&ser_ready.
  - Shift register moves one position toward the output end; vacated bit is filled with 0.
  - counter increments by 1.
  - Counter width is $clog2(N), minimum 1; it never wraps within a frame.
- Transfer at counter==N-1: go to PAR if PARITY_EN, else go to IDLE.
- PAR: ser_valid=1, ser_data=parity register, ser_first=0, ser_last=1. Transfer goes to IDLE.
- Backpressure: with ser_ready=0, ser_data, ser_first, ser_last and all state hold unchanged for any number of cycles.
- Latency and throughput:
  - Word accepted at edge T; first bit is valid in the cycle after T.
  - in_ready returns to 1 in the cycle after the last-bit transfer.
  - Minimum frame period: N+1 cycles (N+2 with parity).
- No overlap: in_valid and in_data are ignored while busy. Upstream must hold them until in_ready=1.
- Edge cases:
  - in_data changing while busy has no effect on the frame in progress.
  - ser_ready high while IDLE has no effect.
  - in_ready is a registered function of state only; it has no combinational path from ser_ready.
- Parity is even: the parity bit equals the XOR of all N data bits, so total ones across the frame is even.

Test Plan:
1. N=8, MSB_FIRST=1, PARITY_EN=0, ser_ready=1, word 8'hA5 -> bits 1,0,1,0,0,1,0,1 on consecutive cycles; ser_first on bit 1; ser_last on bit 8; in_ready=1 one cycle after the last transfer.
2. MSB_FIRST=0, word 8'h1E -> bits 0,1,1,1,1,0,0,0; ser_last on bit 8.
3. PARITY_EN=1, MSB_FIRST=1, word 8'h07 -> 0,0,0,0,0,1,1,1 then parity 1 with ser_last=1 (9 beats); word 8'h03 -> parity bit 0.
4. Backpressure: word 8'hF0, drop ser_ready for 3 cycles after bit 3 -> ser_data stays 1 and ser_valid stays 1 during the stall; the frame completes with the correct remaining bits; total bits seen = 8.
5. Reset mid-frame: assert reset after 4 bits of 8'hAA -> next cycle ser_valid=0, in_ready=1, busy=0; new word 8'hFF then transmits all eight 1s with correct first/last flags.
6. Back-to-back: in_valid held high with 8'h81 then 8'h7E (in_data changing while busy) -> 8'h81 bits fully sent; 8'h7E accepted only in the IDLE cycle; frames separated by exactly one idle cycle; no bits of 8'h7E leak into frame 1.
